// File: rtl/dts_align_ctrl_pkg.sv
// Shared definitions for the DTS lane alignment controller: FSM/tracker encodings and helpers.
// No logic of its own; imported by the controller top and its phase meter.
package dts_align_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MEASURE  = 3'd1,
    ST_PULSE_HI = 3'd2,
    ST_PULSE_LO = 3'd3,
    ST_SETTLE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PEND_NONE  = 2'd0,
    PEND_REF   = 2'd1,
    PEND_LOCAL = 2'd2
  } pend_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dts_align_ctrl_phase_meter.sv
// Measures signed sync offset (local minus ref) in words; result registered one cycle after the match.
// No backpressure: result/timeout are single-cycle strobes, syncs are dropped whenever run is low.
module dts_align_ctrl_phase_meter
  import dts_align_ctrl_pkg::*;
#(
  parameter int MAX_OFFSET = 64,
  parameter int OFS_BITS   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                ref_sync,
  input  logic                local_sync,
  output logic                res_vld,
  output logic [OFS_BITS-1:0] res_ofs,
  output logic                timeout
);

  localparam int CW = $clog2(MAX_OFFSET + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OFFSET);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  pend_t               pend;
  logic [CW-1:0]       cnt;
  logic [OFS_BITS-1:0] cnt_ext;

  always_comb begin
    cnt_ext         = '0;
    cnt_ext[CW-1:0] = cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= PEND_NONE;
      cnt     <= '0;
      res_vld <= 1'b0;
      res_ofs <= '0;
      timeout <= 1'b0;
    end else begin
      res_vld <= 1'b0;
      timeout <= 1'b0;
      if (!run) begin
        pend <= PEND_NONE;
        cnt  <= '0;
      end else if (ref_sync && local_sync) begin
        pend    <= PEND_NONE;
        cnt     <= '0;
        res_vld <= 1'b1;
        res_ofs <= '0;
      end else if (ref_sync) begin
        if (pend == PEND_LOCAL) begin
          // local led: local is early, offset negative
          pend    <= PEND_NONE;
          cnt     <= '0;
          res_vld <= 1'b1;
          res_ofs <= -cnt_ext;
        end else begin
          pend <= PEND_REF;
          cnt  <= CNT_ONE;
        end
      end else if (local_sync) begin
        if (pend == PEND_REF) begin
          pend    <= PEND_NONE;
          cnt     <= '0;
          res_vld <= 1'b1;
          res_ofs <= cnt_ext;
        end else begin
          pend <= PEND_LOCAL;
          cnt  <= CNT_ONE;
        end
      end else if (pend != PEND_NONE) begin
        if (cnt == CNT_MAX) begin
          pend    <= PEND_NONE;
          cnt     <= '0;
          timeout <= 1'b1;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/dts_align_ctrl.sv
// Closed-loop DTS lane aligner: measures sync offset, issues one slip pulse per measurement, reports lock.
// Slip pulse starts the cycle after a decision; no backpressure, enable low returns to idle next cycle.
module dts_align_ctrl
  import dts_align_ctrl_pkg::*;
#(
  parameter int MAX_OFFSET    = 64,
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 256,
  parameter int LOCK_COUNT    = 3,
  parameter int OFS_BITS      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                ref_sync,
  input  logic                local_sync,
  output logic                advance,
  output logic                delay,
  output logic                aligned,
  output logic [OFS_BITS-1:0] offset,
  output logic                timeout_err,
  output logic [15:0]         slip_cnt
);

  localparam int TMAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int LW   = $clog2(LOCK_COUNT + 1);
  localparam logic [TW-1:0] PULSE_LAST  = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_FULL   = LW'(LOCK_COUNT);
  localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_COUNT - 1);

  state_t              state;
  logic [TW-1:0]       timer;
  logic [LW-1:0]       lock_cnt;
  logic                res_vld;
  logic                meter_timeout;
  logic                meter_run;

  assign meter_run = enable && (state == ST_MEASURE);

  dts_align_ctrl_phase_meter #(
    .MAX_OFFSET (MAX_OFFSET),
    .OFS_BITS   (OFS_BITS)
  ) u_meter (
    .clk        (clk),
    .rst        (rst),
    .run        (meter_run),
    .ref_sync   (ref_sync),
    .local_sync (local_sync),
    .res_vld    (res_vld),
    .res_ofs    (offset),
    .timeout    (meter_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      timer       <= '0;
      lock_cnt    <= '0;
      advance     <= 1'b0;
      delay       <= 1'b0;
      aligned     <= 1'b0;
      timeout_err <= 1'b0;
      slip_cnt    <= '0;
    end else begin
      if (meter_timeout) timeout_err <= 1'b1;
      if (!enable) begin
        state    <= ST_IDLE;
        timer    <= '0;
        lock_cnt <= '0;
        advance  <= 1'b0;
        delay    <= 1'b0;
        aligned  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_MEASURE;
          ST_MEASURE: begin
            if (res_vld) begin
              if (offset == '0) begin
                if (lock_cnt != LOCK_FULL) lock_cnt <= lock_cnt + 1'b1;
                if (lock_cnt >= LOCK_LAST) aligned <= 1'b1;
              end else begin
                // sign bit picks direction: local lagging needs an advance
                lock_cnt <= '0;
                aligned  <= 1'b0;
                advance  <= ~offset[OFS_BITS-1];
                delay    <= offset[OFS_BITS-1];
                timer    <= '0;
                slip_cnt <= sat_inc16(slip_cnt);
                state    <= ST_PULSE_HI;
              end
            end
          end
          ST_PULSE_HI: begin
            if (timer == PULSE_LAST) begin
              advance <= 1'b0;
              delay   <= 1'b0;
              timer   <= '0;
              state   <= ST_PULSE_LO;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_PULSE_LO: begin
            if (timer == PULSE_LAST) begin
              timer <= '0;
              state <= ST_SETTLE;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_SETTLE: begin
            if (timer == SETTLE_LAST) begin
              timer <= '0;
              state <= ST_MEASURE;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dts_align_ctrl.sv
// Bench for dts_align_ctrl: emulated offsetter plant that slips the local lane on pulse edges.
// Expectations come from frame-level rules: |delta| slips in the sign's direction, then lock.
module tb_dts_align_ctrl;

  localparam int P     = 400;  // sync period in words
  localparam int PH    = 100;  // ref sync phase within a frame
  localparam int PULSE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       ref_sync;
  logic       local_sync;
  logic       advance;
  logic       delay;
  logic       aligned;
  logic [7:0] offset;
  logic       timeout_err;
  logic [15:0] slip_cnt;

  dts_align_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .ref_sync    (ref_sync),
    .local_sync  (local_sync),
    .advance     (advance),
    .delay       (delay),
    .aligned     (aligned),
    .offset      (offset),
    .timeout_err (timeout_err),
    .slip_cnt    (slip_cnt)
  );

  always #5 clk = ~clk;

  // main-block controls
  int lag_base = 0;
  bit ref_on = 1'b1;
  bit loc_on = 1'b1;
  // plant-owned state
  int cyc = 0;
  int slip_adj = 0;
  int adv_pulses = 0;
  int del_pulses = 0;
  int both_high = 0;
  int bad_width = 0;
  int run_len = 0;
  bit adv_q = 1'b0;
  bit del_q = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  // plant: offsetter shifts local one word per rising pulse edge
  initial begin
    ref_sync   = 1'b0;
    local_sync = 1'b0;
    forever begin
      @(negedge clk);
      if (advance && !adv_q) begin adv_pulses++; slip_adj--; end
      if (delay && !del_q) begin del_pulses++; slip_adj++; end
      if (advance && delay) both_high++;
      if (advance || delay) run_len++;
      else if (adv_q || del_q) begin
        if (run_len != PULSE) bad_width++;
        run_len = 0;
      end
      adv_q = advance;
      del_q = delay;
      cyc++;
      ref_sync   = ref_on && ((cyc % P) == PH);
      local_sync = loc_on && (((((cyc - lag_base - slip_adj) % P) + P) % P) == PH);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    ticks(3);
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_phase(input int ph);
    while ((cyc % P) != ph) tick();
  endtask

  task automatic wait_pulse(input int budget, output bit ok);
    int n = 0;
    while (!(advance || delay) && n < budget) begin tick(); n++; end
    ok = advance || delay;
  endtask

  task automatic wait_aligned(input int budget, output bit ok);
    int n = 0;
    while (!aligned && n < budget) begin tick(); n++; end
    ok = aligned;
  endtask

  task automatic wait_ref(input int budget, output bit ok);
    int n = 0;
    tick();
    while (!ref_sync && n < budget) begin tick(); n++; end
    ok = ref_sync;
  endtask

  // shift local by delta words from a locked state and expect |delta| slips then relock
  task automatic shift_round(input string tag, input int delta, inout int exp_slip);
    bit ok;
    int a0, d0;
    wait_phase(300);
    a0 = adv_pulses;
    d0 = del_pulses;
    lag_base = lag_base + delta;
    if (delta == 0) begin
      ticks(2 * P);
      check({tag, "_still_aligned"}, int'(aligned), 1);
    end else begin
      wait_pulse(3 * P, ok);
      check({tag, "_pulse_seen"}, int'(ok), 1);
      check({tag, "_first_offset"}, int'($signed(offset)), delta);
      check({tag, "_aligned_drop"}, int'(aligned), 0);
      wait_aligned((delta < 0 ? -delta : delta) * P + 5 * P, ok);
      check({tag, "_relock"}, int'(ok), 1);
      exp_slip += (delta < 0) ? -delta : delta;
    end
    check({tag, "_adv"}, adv_pulses - a0, (delta > 0) ? delta : 0);
    check({tag, "_del"}, del_pulses - d0, (delta < 0) ? -delta : 0);
    check({tag, "_slip_cnt"}, int'(slip_cnt), exp_slip);
  endtask

  initial begin
    bit ok;
    int exp_slip;
    int a0;
    int d0;
    int delta;
    rst = 1'b1;
    enable = 1'b0;

    // reset state
    do_reset();
    check("rst_advance", int'(advance), 0);
    check("rst_delay", int'(delay), 0);
    check("rst_aligned", int'(aligned), 0);
    check("rst_offset", int'(offset), 0);
    check("rst_timeout", int'(timeout_err), 0);
    check("rst_slip", int'(slip_cnt), 0);

    // local lags by 3: three advances, then lock
    lag_base = 3 - slip_adj;
    a0 = adv_pulses; d0 = del_pulses;
    enable = 1'b1;
    wait_pulse(3 * P, ok);
    check("lag3_pulse_seen", int'(ok), 1);
    check("lag3_first_offset", int'($signed(offset)), 3);
    check("lag3_advance_dir", int'(advance), 1);
    wait_aligned(10 * P, ok);
    check("lag3_lock", int'(ok), 1);
    check("lag3_adv", adv_pulses - a0, 3);
    check("lag3_del", del_pulses - d0, 0);
    check("lag3_slip", int'(slip_cnt), 3);
    check("lag3_offset_final", int'($signed(offset)), 0);
    exp_slip = 3;

    // locked lane shifts by one word, then random shifts
    shift_round("shift_p1", 1, exp_slip);
    for (int r = 0; r < 4; r++) begin
      delta = int'($urandom_range(12)) - 6;
      shift_round($sformatf("rand%0d", r), delta, exp_slip);
    end
    check("pulse_width_errs", bad_width, 0);
    check("both_high", both_high, 0);

    // local leads by 2: two delays
    do_reset();
    lag_base = -2 - slip_adj;
    a0 = adv_pulses; d0 = del_pulses;
    enable = 1'b1;
    wait_pulse(3 * P, ok);
    check("lead2_pulse_seen", int'(ok), 1);
    check("lead2_first_offset", int'($signed(offset)), -2);
    check("lead2_delay_dir", int'(delay), 1);
    wait_aligned(10 * P, ok);
    check("lead2_lock", int'(ok), 1);
    check("lead2_adv", adv_pulses - a0, 0);
    check("lead2_del", del_pulses - d0, 2);
    check("lead2_slip", int'(slip_cnt), 2);

    // coincident syncs: lock on exactly the third frame
    do_reset();
    lag_base = -slip_adj;
    a0 = adv_pulses; d0 = del_pulses;
    wait_phase(200);
    enable = 1'b1;
    wait_ref(2 * P, ok);
    wait_ref(2 * P, ok);
    ticks(5);
    check("coin_not_yet_2", int'(aligned), 0);
    wait_ref(2 * P, ok);
    check("coin_ref3_seen", int'(ok), 1);
    tick();
    check("coin_not_yet_3", int'(aligned), 0);
    tick();
    check("coin_aligned_3", int'(aligned), 1);
    check("coin_no_pulses", (adv_pulses - a0) + (del_pulses - d0), 0);
    check("coin_slip", int'(slip_cnt), 0);

    // local sync absent: timeout after MAX_OFFSET words
    do_reset();
    loc_on = 1'b0;
    a0 = adv_pulses;
    enable = 1'b1;
    wait_ref(2 * P, ok);
    check("to_ref_seen", int'(ok), 1);
    ticks(60);
    check("to_not_early", int'(timeout_err), 0);
    ticks(10);
    check("to_set", int'(timeout_err), 1);
    ticks(P);
    check("to_sticky", int'(timeout_err), 1);
    check("to_no_pulses", adv_pulses - a0, 0);
    check("to_aligned", int'(aligned), 0);
    check("to_slip", int'(slip_cnt), 0);
    loc_on = 1'b1;

    // reset during a pulse
    do_reset();
    lag_base = 3 - slip_adj;
    enable = 1'b1;
    wait_pulse(3 * P, ok);
    check("rstmid_pulse_seen", int'(ok), 1);
    tick();
    rst = 1'b1;
    tick();
    check("rstmid_advance", int'(advance), 0);
    check("rstmid_slip", int'(slip_cnt), 0);
    check("rstmid_offset", int'(offset), 0);
    rst = 1'b0;

    // enable drop during a pulse keeps measurement and stats
    lag_base = 3 - slip_adj;
    tick();
    wait_pulse(3 * P, ok);
    check("endrop_pulse_seen", int'(ok), 1);
    tick();
    enable = 1'b0;
    tick();
    check("endrop_advance", int'(advance), 0);
    check("endrop_aligned", int'(aligned), 0);
    check("endrop_slip", int'(slip_cnt), 1);
    check("endrop_offset", int'($signed(offset)), 3);
    ticks(P);
    check("endrop_idle_quiet", int'(advance || delay), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
